// File: rtl/streetlight_pkg.sv
`default_nettype none
// ============================================================================
// Module  : streetlight_pkg
// Purpose : Shared definitions for the street-lighting zone scheduler:
//           global mode encoding, default lamp duty levels and a clog2
//           helper used to size counters.
// Ports   : (package, none)
// Rev     : 1.0  initial release
// ============================================================================
package streetlight_pkg;

    // Global lighting mode; the encoding is visible on the mode output.
    typedef enum logic [1:0] {
        MODE_DAY          = 2'b00,
        MODE_NIGHT_IDLE   = 2'b01,
        MODE_NIGHT_ACTIVE = 2'b10
    } mode_e;

    localparam int DEF_DIM_LEVEL  = 4;
    localparam int DEF_FULL_LEVEL = 15;

    // Number of bits needed to index 'value' distinct states (minimum 1).
    function automatic int clog2(input int value);
        int v;
        int bits;
        v    = value - 1;
        bits = 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        if (bits == 0) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage : streetlight_pkg
`default_nettype wire

// File: rtl/sl_debounce.sv
`default_nettype none
// ============================================================================
// Module  : sl_debounce
// Purpose : Single-bit debouncer. The stable output only follows the raw
//           input after it has differed for DAY_DEBOUNCE consecutive edges.
// Ports   : clk      in  system clock
//           rst      in  asynchronous active-high reset (stable resets to 1)
//           sig_i    in  raw input
//           stable_o out debounced level (registered)
//           rise_o   out high during the cycle whose edge makes stable_o rise
// Rev     : 1.0  initial release
// ============================================================================
module sl_debounce
    import streetlight_pkg::*;
#(
    parameter int DAY_DEBOUNCE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic stable_o,
    output logic rise_o
);

    localparam int CW = clog2(DAY_DEBOUNCE + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stable_q;
    logic          stable_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_o   = 1'b0;
        if (sig_i != stable_q) begin
            // The edge that would bring the count to DAY_DEBOUNCE toggles
            // instead, so the toggle lands on the Nth differing edge.
            if (cnt_q == CW'(DAY_DEBOUNCE - 1)) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
                rise_o   = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule : sl_debounce
`default_nettype wire

// File: rtl/streetlight_zone_sched.sv
`default_nettype none
// ============================================================================
// Module  : streetlight_zone_sched
// Purpose : Night-time street lighting scheduler. Debounces the daylight
//           sensor, runs the DAY / NIGHT_IDLE / NIGHT_ACTIVE mode machine,
//           keeps a per-zone hold timer loaded by vehicle detection (plus
//           LOOKAHEAD downstream zones) and drives one PWM output per lamp.
// Ports   : clk          in  system clock
//           rst          in  asynchronous active-high reset
//           day          in  raw daylight sensor, 1 = daylight
//           veh_detect   in  per-zone vehicle sensors
//           lamp_pwm     out per-lamp PWM drive (registered)
//           zone_bright  out zone hold timer nonzero (registered)
//           mode         out 00 DAY, 01 NIGHT_IDLE, 10 NIGHT_ACTIVE
//           day_stable   out debounced daylight
// Rev     : 1.0  initial release
// ============================================================================
module streetlight_zone_sched
    import streetlight_pkg::*;
#(
    parameter int NUM_ZONES    = 4,
    parameter int HOLD_CYC     = 64,
    parameter int LOOKAHEAD    = 1,
    parameter int DAY_DEBOUNCE = 8,
    parameter int PWM_BITS     = 4,
    parameter int DIM_LEVEL    = DEF_DIM_LEVEL,
    parameter int FULL_LEVEL   = DEF_FULL_LEVEL
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 day,
    input  logic [NUM_ZONES-1:0] veh_detect,
    output logic [NUM_ZONES-1:0] lamp_pwm,
    output logic [NUM_ZONES-1:0] zone_bright,
    output logic [1:0]           mode,
    output logic                 day_stable
);

    localparam int TW = clog2(HOLD_CYC + 1);

    logic                 day_stable_w;
    logic                 day_rise_w;
    logic                 clear_all_w;
    logic                 any_timer_w;
    mode_e                mode_q;
    mode_e                mode_d;
    logic [TW-1:0]        timer_q [NUM_ZONES];
    logic [TW-1:0]        timer_d [NUM_ZONES];
    logic [NUM_ZONES-1:0] load_w;
    logic [NUM_ZONES-1:0] bright_q;
    logic [NUM_ZONES-1:0] bright_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q;
    logic [PWM_BITS-1:0]  level_w [NUM_ZONES];
    logic [NUM_ZONES-1:0] lamp_q;
    logic [NUM_ZONES-1:0] lamp_d;

    sl_debounce #(
        .DAY_DEBOUNCE(DAY_DEBOUNCE)
    ) u_day_debounce (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (day),
        .stable_o(day_stable_w),
        .rise_o  (day_rise_w)
    );

    // Timers are wiped on the same edge day_stable rises, so daylight wins
    // over any detection arriving in that cycle.
    assign clear_all_w = (mode_q == MODE_DAY) || day_rise_w;

    // Sensor j lights zones j..j+LOOKAHEAD; no wrap past the last zone.
    always_comb begin
        load_w = '0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            for (int j = 0; j < NUM_ZONES; j++) begin
                if ((j <= i) && ((i - j) <= LOOKAHEAD)) begin
                    load_w[i] = load_w[i] | veh_detect[j];
                end
            end
        end
    end

    always_comb begin
        any_timer_w = 1'b0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            if (clear_all_w) begin
                timer_d[i] = '0;
            end else if (load_w[i]) begin
                timer_d[i] = TW'(HOLD_CYC);
            end else if (timer_q[i] != '0) begin
                timer_d[i] = timer_q[i] - 1'b1;
            end else begin
                timer_d[i] = timer_q[i];
            end
            bright_d[i] = (timer_d[i] != '0);
            any_timer_w = any_timer_w | (timer_q[i] != '0);
        end
    end

    // Mode machine: daylight (current or arriving this edge) has priority.
    always_comb begin
        mode_d = mode_q;
        if (day_stable_w || day_rise_w) begin
            mode_d = MODE_DAY;
        end else begin
            case (mode_q)
                MODE_DAY:          mode_d = MODE_NIGHT_IDLE;
                MODE_NIGHT_IDLE:   if (any_timer_w) mode_d = MODE_NIGHT_ACTIVE;
                MODE_NIGHT_ACTIVE: if (!any_timer_w) mode_d = MODE_NIGHT_IDLE;
                default:           mode_d = MODE_DAY;
            endcase
        end
    end

    // Duty levels derive from the registered timers, so a brightness change
    // reaches lamp_pwm one edge after the timer changes.
    always_comb begin
        for (int i = 0; i < NUM_ZONES; i++) begin
            if (mode_q == MODE_DAY) begin
                level_w[i] = '0;
            end else if (timer_q[i] != '0) begin
                level_w[i] = PWM_BITS'(FULL_LEVEL);
            end else begin
                level_w[i] = PWM_BITS'(DIM_LEVEL);
            end
            lamp_d[i] = (pwm_cnt_q < level_w[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_DAY;
            bright_q  <= '0;
            lamp_q    <= '0;
            pwm_cnt_q <= '0;
        end else begin
            mode_q    <= mode_d;
            bright_q  <= bright_d;
            lamp_q    <= lamp_d;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < NUM_ZONES; g++) begin : g_timer
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    timer_q[g] <= '0;
                end else begin
                    timer_q[g] <= timer_d[g];
                end
            end
        end
    endgenerate

    assign lamp_pwm    = lamp_q;
    assign zone_bright = bright_q;
    assign mode        = mode_q;
    assign day_stable  = day_stable_w;

endmodule : streetlight_zone_sched
`default_nettype wire
